// File: rtl/mux8_scan.sv
// mux8_scan: sequential 8-to-1 multiplexer feeding a downstream 8-way demultiplexer.
//
// One of eight parallel bits is placed on a serial line (q). The 3-bit select address is
// driven out so the demultiplexer can route that bit back to the matching output. The
// address advances either automatically, once every TICK_DIV cycles (SCAN), or manually,
// once per rising edge of a debounced pushbutton (IDLE).
//
// Parameters:
//   TICK_DIV  clock cycles per automatic address step (>= 2)
//   CNT_W     prescaler width, derived from TICK_DIV
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   rst    in   synchronous active-high reset
//   din    in   [7:0] parallel source bits; din[i] is sent while addr == i
//   run    in   1 = automatic scanning, 0 = manual / idle
//   step   in   manual advance, synchronous and debounced, rising-edge sensitive
//   addr   out  [2:0] current select address (addr[2] = a2 ... addr[0] = a0)
//   q      out  selected bit, shadow[addr]
//   frame  out  one-cycle pulse in the first cycle addr == 0 after a 7 -> 0 wrap
//   busy   out  high while scanning automatically
module mux8_scan #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = $clog2(TICK_DIV)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       run,
  input  logic       step,
  output logic [2:0] addr,
  output logic       q,
  output logic       frame,
  output logic       busy
);

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } state_e;

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       AddrMax = 3'd7;

  state_e           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             step_prev_q;
  logic             frame_q, frame_d;

  logic step_rise;
  logic advance;

  assign step_rise = step & ~step_prev_q;

  // Next-state logic. "advance" is raised by whichever mode owns the address this cycle;
  // the address increment and the frame/shadow wrap handling are shared below.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    advance  = 1'b0;

    case (state_q)
      StIdle: begin
        // Transparent: live switches are visible on q while idle.
        shadow_d = din;
        cnt_d    = '0;
        if (run) begin
          // Entering SCAN never advances, even with a coincident step edge.
          state_d = StScan;
        end else if (step_rise) begin
          advance = 1'b1;
        end
      end

      StScan: begin
        if (!run) begin
          // Leaving SCAN wins over a tick landing in the same cycle.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      addr_d = addr_q + 3'd1;
      if (addr_q == AddrMax) begin
        // Latch a fresh frame only at the wrap so all eight bits sent in SCAN are coherent.
        shadow_d = din;
        frame_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      step_prev_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      step_prev_q <= step;
      frame_q     <= frame_d;
    end
  end

  assign addr  = addr_q;
  assign q     = shadow_q[addr_q];
  assign frame = frame_q;
  assign busy  = (state_q == StScan);

endmodule

// File: tb/tb_mux8_scan.sv
// Testbench for mux8_scan with TICK_DIV = 4: directed vectors for reset, manual stepping,
// auto scan, frame coherency, run drop and mid-operation reset, then randomized stimulus
// compared every cycle against a behavioural reference model.
module tb_mux8_scan;

  localparam int unsigned TickDiv = 4;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       run;
  logic       step;
  logic [2:0] addr;
  logic       q;
  logic       frame;
  logic       busy;

  int total = 0;
  int bad   = 0;

  mux8_scan #(
    .TICK_DIV(TickDiv)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .run  (run),
    .step (step),
    .addr (addr),
    .q    (q),
    .frame(frame),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: address position, scan mode, cycles spent on the current address,
  // frame snapshot and the previous step level.
  bit         m_scan;
  int         m_addr;
  int         m_dwell;
  logic [7:0] m_shadow;
  bit         m_prev_step;
  bit         m_frame;

  task automatic model_update();
    bit adv;
    bit rise;
    adv = 1'b0;
    if (rst) begin
      m_scan      = 1'b0;
      m_addr      = 0;
      m_dwell     = 0;
      m_shadow    = 8'h00;
      m_prev_step = 1'b0;
      m_frame     = 1'b0;
      return;
    end
    rise        = step && !m_prev_step;
    m_prev_step = step;
    m_frame     = 1'b0;
    if (!m_scan) begin
      m_shadow = din;
      if (run) begin
        m_scan  = 1'b1;
        m_dwell = 0;
      end else if (rise) begin
        adv = 1'b1;
      end
    end else if (!run) begin
      m_scan  = 1'b0;
      m_dwell = 0;
    end else begin
      m_dwell = m_dwell + 1;
      if (m_dwell == int'(TickDiv)) begin
        m_dwell = 0;
        adv     = 1'b1;
      end
    end
    if (adv) begin
      if (m_addr == 7) begin
        m_shadow = din;
        m_frame  = 1'b1;
      end
      m_addr = (m_addr + 1) % 8;
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs read 1 ns after the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [2:0] exp_addr;
    logic       exp_q;
    logic       exp_frame;
  } step_vec_t;

  step_vec_t tbl[9];

  initial begin
    logic [7:0] pat;
    int         ea;

    // din = 1010_0101: bit i is sent at addr i
    tbl[0] = '{8'hA5, 3'd1, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 3'd2, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 3'd3, 1'b0, 1'b0};
    tbl[3] = '{8'hA5, 3'd4, 1'b0, 1'b0};
    tbl[4] = '{8'hA5, 3'd5, 1'b1, 1'b0};
    tbl[5] = '{8'hA5, 3'd6, 1'b0, 1'b0};
    tbl[6] = '{8'hA5, 3'd7, 1'b1, 1'b0};
    tbl[7] = '{8'hA5, 3'd0, 1'b1, 1'b1};
    tbl[8] = '{8'hA5, 3'd1, 1'b0, 1'b0};

    rst  = 1'b1;
    din  = 8'hFF;
    run  = 1'b1;
    step = 1'b0;
    m_scan = 1'b0; m_addr = 0; m_dwell = 0; m_shadow = 8'h00; m_prev_step = 1'b0;
    m_frame = 1'b0;

    // Reset holds everything at zero even with run = 1 and din = FF.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_addr", int'(addr), 0);
      check("rst_q", int'(q), 0);
      check("rst_frame", int'(frame), 0);
      check("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    tick();
    check("run_after_rst_busy", int'(busy), 1);
    check("run_after_rst_addr", int'(addr), 0);
    check("run_after_rst_frame", int'(frame), 0);
    check("run_after_rst_q", int'(q), 1);

    // Manual stepping.
    run = 1'b0;
    tick();
    check("idle_busy", int'(busy), 0);
    check("idle_addr", int'(addr), 0);
    din = 8'hA5;
    tick();
    check("idle_live_q", int'(q), 1);
    for (int i = 0; i < 9; i++) begin
      din  = tbl[i].din;
      step = 1'b1;
      tick();
      check("man_addr", int'(addr), int'(tbl[i].exp_addr));
      check("man_q", int'(q), int'(tbl[i].exp_q));
      check("man_frame", int'(frame), int'(tbl[i].exp_frame));
      tick();
      check("man_hold_addr", int'(addr), int'(tbl[i].exp_addr));
      check("man_frame_off", int'(frame), 0);
      step = 1'b0;
      repeat (3) tick();
      check("man_low_addr", int'(addr), int'(tbl[i].exp_addr));
    end
    step = 1'b1;
    repeat (10) tick();
    check("man_long_hold_addr", int'(addr), 2);
    step = 1'b0;
    tick();

    // Auto scan from addr 0 with din = 3C; din switches to C3 at addr 3 and must not
    // appear on q until the wrap.
    rst = 1'b1;
    run = 1'b0;
    tick();
    rst = 1'b0;
    din = 8'h3C;
    run = 1'b1;
    tick();
    check("scan_entry_busy", int'(busy), 1);
    check("scan_entry_addr", int'(addr), 0);
    check("scan_entry_frame", int'(frame), 0);
    check("scan_entry_q", int'(q), 0);
    for (int k = 1; k <= 55; k++) begin
      tick();
      ea  = (k / int'(TickDiv)) % 8;
      pat = (k >= 32) ? 8'hC3 : 8'h3C;
      check("scan_addr", int'(addr), ea);
      check("scan_q", int'(q), int'(pat[ea]));
      check("scan_frame", int'(frame), (k == 32) ? 1 : 0);
      check("scan_busy", int'(busy), 1);
      if (k == 12) din = 8'hC3;
    end

    // run dropped in the cycle the prescaler would tick: no advance.
    run = 1'b0;
    tick();
    check("drop_addr", int'(addr), 5);
    check("drop_busy", int'(busy), 0);
    check("drop_frame", int'(frame), 0);
    run = 1'b1;
    tick();
    check("rerun_busy", int'(busy), 1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check("rerun_addr", int'(addr), (j == 4) ? 6 : 5);
    end

    // Reset at addr 6, cnt 2.
    repeat (2) tick();
    check("pre_rst_addr", int'(addr), 6);
    rst = 1'b1;
    tick();
    check("midrst_addr", int'(addr), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame", int'(frame), 0);
    check("midrst_q", int'(q), 0);
    rst = 1'b0;
    tick();
    check("post_rst_busy", int'(busy), 1);
    // Fresh count after reset: first advance TickDiv cycles after entering SCAN.
    for (int j = 1; j <= int'(TickDiv); j++) begin
      tick();
      check("post_rst_addr", int'(addr), (j == int'(TickDiv)) ? 1 : 0);
    end

    // Randomized stimulus against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 24) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) step = ~step;
      if ($urandom_range(0, 9) == 0) din = 8'($urandom);
      tick();
      check("rnd_addr", int'(addr), m_addr);
      check("rnd_q", int'(q), int'(m_shadow[m_addr]));
      check("rnd_frame", int'(frame), int'(m_frame));
      check("rnd_busy", int'(busy), int'(m_scan));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
